fdtd_calc_ez_stream: RTL and testbench

- Streaming E-field update engine for the 1-D FDTD core; the companion to the Hy update path, driving the opposite half of the leapfrog step.
- Per cell k: Ez_new[k] = ceze*Ez_old[k] + cezh*(Hy[k] - Hy[k-1]) + source term.
- Consumes one cell per valid/ready handshake over a sweep of NUM_CELLS cells, with a PEC wall at cell 0.
- Plain-RTL pipeline with no vendor IP; a start/done sequencer is driven by the FDTD controller.

---
 rtl/fdtd_calc_ez_stream.sv | 217 +++++++++++++++++++++
 tb/tb_fdtd_calc_ez_stream.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_calc_ez_stream.sv
// Streaming E-field update engine for the 1-D FDTD core.
//
// Per accepted cell k:
//   Ez_n_o = t(ceze*Ez_old[k]) + t(cezh*(Hy[k] - Hy[k-1])) + (src_en && k==src_idx ? src_val : 0)
// where t(p) keeps {sign, p[CUT_LT:CUT_RT]} of the full 2W-bit product (floor, no rounding).
// Cell 0 is a PEC wall and always produces 0.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   start             one-cycle sweep request (ignored unless idle)
//   ceze, cezh        update coefficients, 1.0 = 2^CUT_RT, held stable while busy
//   src_en/idx/val    additive source injection at one cell
//   in_valid/in_ready input cell handshake carrying Ez_old_i and Hy_i
//   out_valid/ready   output handshake carrying Ez_n_o and its cell index out_idx
//   busy              sweep in progress
//   done              one-cycle pulse after the last result has been taken
//
// Three-stage pipeline (register inputs / multiply / truncate-and-sum) with a single global
// enable, so a stalled output freezes every stage and back-pressures the input.

module fdtd_calc_ez_stream #(
  parameter int unsigned FDTD_DATA_WIDTH = 32,
  parameter int unsigned CUT_LT          = 51,
  parameter int unsigned CUT_RT          = 21,
  parameter int unsigned NUM_CELLS       = 200,
  parameter int unsigned IDX_WIDTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  input  logic [FDTD_DATA_WIDTH-1:0] ceze,
  input  logic [FDTD_DATA_WIDTH-1:0] cezh,
  input  logic                       src_en,
  input  logic [IDX_WIDTH-1:0]       src_idx,
  input  logic [FDTD_DATA_WIDTH-1:0] src_val,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FDTD_DATA_WIDTH-1:0] Ez_old_i,
  input  logic [FDTD_DATA_WIDTH-1:0] Hy_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FDTD_DATA_WIDTH-1:0] Ez_n_o,
  output logic [IDX_WIDTH-1:0]       out_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned W  = FDTD_DATA_WIDTH;
  localparam int unsigned PW = 2 * FDTD_DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CELLS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         hy_prev_q, hy_prev_d;
  logic                 done_q, done_d;

  // Stage 1: registered inputs and Hy difference.
  logic                 v1_q, v1_d;
  logic [W-1:0]         d1_q, d1_d;
  logic [W-1:0]         ez1_q, ez1_d;
  logic [IDX_WIDTH-1:0] k1_q, k1_d;
  logic                 pec1_q, pec1_d;

  // Stage 2: full-width products.
  logic                 v2_q, v2_d;
  logic signed [PW-1:0] p0_q, p0_d;
  logic signed [PW-1:0] p1_q, p1_d;
  logic [IDX_WIDTH-1:0] k2_q, k2_d;
  logic                 pec2_q, pec2_d;

  // Stage 3: result.
  logic                 v3_q, v3_d;
  logic [W-1:0]         ez3_q, ez3_d;
  logic [IDX_WIDTH-1:0] k3_q, k3_d;

  logic         en;
  logic         accept;
  logic         drain_done;
  logic [W-1:0] src_term;
  logic [W-1:0] sum;

  function automatic logic [W-1:0] trunc_prod(input logic [PW-1:0] p);
    return {p[PW-1], p[CUT_LT:CUT_RT]};
  endfunction

  assign out_valid = v3_q;
  assign Ez_n_o    = ez3_q;
  assign out_idx   = k3_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  assign en       = !(v3_q && !out_ready);
  assign in_ready = (state_q == StRun) && en;
  assign accept   = in_valid && in_ready;

  // Nothing left in stages 1-2 and stage 3 is either empty or handing off this cycle.
  assign drain_done = !v1_q && !v2_q && (!v3_q || out_ready);

  // Out-of-range src_idx never matches because k stays below NUM_CELLS.
  assign src_term = (src_en && (k2_q == src_idx)) ? src_val : '0;
  assign sum      = trunc_prod(p0_q) + trunc_prod(p1_q) + src_term;

  // Sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hy_prev_d = hy_prev_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          cnt_d     = '0;
          hy_prev_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d     = cnt_q + 1'b1;
          hy_prev_d = Hy_i;
          if (cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_done) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pipeline next state; every stage holds when en is low.
  always_comb begin
    v1_d   = v1_q;
    d1_d   = d1_q;
    ez1_d  = ez1_q;
    k1_d   = k1_q;
    pec1_d = pec1_q;
    v2_d   = v2_q;
    p0_d   = p0_q;
    p1_d   = p1_q;
    k2_d   = k2_q;
    pec2_d = pec2_q;
    v3_d   = v3_q;
    ez3_d  = ez3_q;
    k3_d   = k3_q;
    if (en) begin
      v1_d = accept;
      if (accept) begin
        d1_d   = Hy_i - hy_prev_q;
        ez1_d  = Ez_old_i;
        k1_d   = cnt_q;
        pec1_d = (cnt_q == '0);
      end
      v2_d = v1_q;
      if (v1_q) begin
        p0_d   = $signed(ez1_q) * $signed(ceze);
        p1_d   = $signed(d1_q) * $signed(cezh);
        k2_d   = k1_q;
        pec2_d = pec1_q;
      end
      v3_d = v2_q;
      if (v2_q) begin
        ez3_d = pec2_q ? '0 : sum;
        k3_d  = k2_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hy_prev_q <= '0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      d1_q      <= '0;
      ez1_q     <= '0;
      k1_q      <= '0;
      pec1_q    <= 1'b0;
      v2_q      <= 1'b0;
      p0_q      <= '0;
      p1_q      <= '0;
      k2_q      <= '0;
      pec2_q    <= 1'b0;
      v3_q      <= 1'b0;
      ez3_q     <= '0;
      k3_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hy_prev_q <= hy_prev_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
      d1_q      <= d1_d;
      ez1_q     <= ez1_d;
      k1_q      <= k1_d;
      pec1_q    <= pec1_d;
      v2_q      <= v2_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      k2_q      <= k2_d;
      pec2_q    <= pec2_d;
      v3_q      <= v3_d;
      ez3_q     <= ez3_d;
      k3_q      <= k3_d;
    end
  end

endmodule

// File: tb/tb_fdtd_calc_ez_stream.sv
// Self-checking bench for fdtd_calc_ez_stream with a 4-cell sweep.
// A behavioural model predicts every result from the update equation; one compare process
// checks outputs, in_ready, busy and done on every falling edge. Directed sweeps pin the model
// with hand-computed values, then randomized sweeps follow.

module tb_fdtd_calc_ez_stream;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ceze = '0;
  logic [31:0] cezh = '0;
  logic        src_en = 1'b0;
  logic [15:0] src_idx = '0;
  logic [31:0] src_val = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Ez_old_i = '0;
  logic [31:0] Hy_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Ez_n_o;
  logic [15:0] out_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fdtd_calc_ez_stream #(
    .NUM_CELLS(N)
  ) u_dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .start    (start),
    .ceze     (ceze),
    .cezh     (cezh),
    .src_en   (src_en),
    .src_idx  (src_idx),
    .src_val  (src_val),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Ez_old_i (Ez_old_i),
    .Hy_i     (Hy_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Ez_n_o   (Ez_n_o),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] val;
    int          idx;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  bit          mbusy = 0;
  int          mcount = 0;
  logic [31:0] mhy_prev = '0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          first_acc = -1;
  int          first_out = -1;
  logic [31:0] got [N];

  // Coefficient product scaled by 2^-21 with floor; the kept field is 31 bits plus the sign.
  function automatic logic [31:0] scaled(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [31:0] r;
    p     = longint'($signed(a)) * longint'($signed(b));
    r     = 32'(p >>> 21);
    r[31] = p[63];
    return r;
  endfunction

  function automatic logic [31:0] model_cell(input logic [31:0] ez, input logic [31:0] hy,
                                             input logic [31:0] hprev, input int k);
    logic [31:0] s;
    logic [31:0] dh;
    if (k == 0) return 32'h0;
    dh = hy - hprev;
    s  = scaled(ez, ceze) + scaled(dh, cezh);
    if (src_en && (src_idx == k)) s = s + src_val;
    return s;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    bit stalled;
    bit busy_now;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs", {in_ready, out_valid, busy, done, Ez_n_o, out_idx}, 64'h0);
        q.delete();
        mbusy    = 0;
        mcount   = 0;
        mhy_prev = '0;
        exp_busy = 0;
        exp_done = 0;
      end else begin
        stalled = out_valid && !out_ready;
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        if (done) done_cnt++;
        chk("in_ready", in_ready, mbusy && (mcount < N) && !stalled);
        busy_now = mbusy;
        exp_done = 0;
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_output", out_valid, 1'b0);
          end else begin
            chk("ez_value", Ez_n_o, q[0].val);
            chk("out_idx", out_idx, q[0].idx);
            chk("latency_ge3", (cyc - q[0].cyc) >= 3, 1'b1);
            if (first_out < 0) first_out = cyc;
            if (out_ready) begin
              got[q[0].idx] = Ez_n_o;
              if (q[0].idx == N - 1) begin
                exp_done = 1;
                exp_busy = 0;
                mbusy    = 0;
              end
              void'(q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          if (first_acc < 0) first_acc = cyc;
          q.push_back('{model_cell(Ez_old_i, Hy_i, mhy_prev, mcount), mcount, cyc});
          mhy_prev = Hy_i;
          mcount++;
        end
        if (start && !busy_now) begin
          mbusy     = 1;
          exp_busy  = 1;
          mcount    = 0;
          mhy_prev  = '0;
          first_acc = -1;
          first_out = -1;
          for (int i = 0; i < N; i++) got[i] = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int       rmode = 0;
  bit [5:0] rpat = 6'b101001;  // 1,0,0,1,0,1 from bit 0
  initial begin
    int rc;
    rc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = rpat[rc % 6]; rc++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ez_arr [N];
  logic [31:0] hy_arr [N];
  logic [31:0] basic_exp [N];
  bit [5:0]    vpat = 6'b101101;  // 1,0,1,1,0,1 from bit 0

  task automatic load_basic();
    ceze   = 32'h0020_0000;
    cezh   = 32'h0010_0000;
    src_en = 1'b0;
    ez_arr = '{32'd10, 32'd20, 32'd30, 32'd40};
    hy_arr = '{32'd2, 32'd6, 32'd4, 32'd4};
  endtask

  task automatic sweep(input int vmode, input bit restart);
    int k;
    int n;
    int dc0;
    bit hs;
    dc0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    n = 0;
    while (k < N) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = vpat[n % 6];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      Ez_old_i = ez_arr[k];
      Hy_i     = hy_arr[k];
      start    = restart && (n == 2);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      n++;
      if (n > 500) begin
        chk("accept_timeout", k, N);
        break;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 300 && done_cnt == dc0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - dc0, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic check_basic(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s_cell%0d", tag, i), got[i], basic_exp[i]);
  endtask

  initial begin
    basic_exp = '{32'd0, 32'd22, 32'd29, 32'd40};
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic sweep, exact first-result latency.
    load_basic();
    rmode = 0;
    sweep(0, 1'b0);
    check_basic("basic");
    chk("first_latency", first_out - first_acc, 3);

    // Source at cell 2, then at the PEC cell.
    load_basic();
    src_en  = 1'b1;
    src_idx = 16'd2;
    src_val = 32'd100;
    sweep(0, 1'b0);
    chk("src2_cell2", got[2], 32'd129);
    chk("src2_cell1", got[1], 32'd22);
    src_idx = 16'd0;
    sweep(0, 1'b0);
    chk("src0_cell0", got[0], 32'd0);
    chk("src0_cell2", got[2], 32'd29);

    // Backpressure pattern.
    load_basic();
    rmode = 1;
    sweep(0, 1'b0);
    check_basic("bp");
    rmode = 0;

    // Wraparound.
    ceze   = 32'h0020_0000;
    cezh   = 32'h0020_0000;
    src_en = 1'b0;
    ez_arr = '{32'd5, 32'h7FFF_FFFF, 32'd0, 32'd0};
    hy_arr = '{32'd0, 32'd1, 32'd1, 32'd1};
    sweep(0, 1'b0);
    chk("wrap_cell1", got[1], 32'h8000_0000);

    // Start pulsed mid-run is ignored.
    load_basic();
    sweep(0, 1'b1);
    check_basic("restart");

    // Reset mid-sweep, then a clean sweep.
    begin
      int dc0;
      dc0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      in_valid = 1'b1;
      Ez_old_i = 32'd77;
      Hy_i     = 32'd9;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_cnt - dc0, 0);
    end
    load_basic();
    sweep(0, 1'b0);
    check_basic("post_reset");

    // Bubbles.
    load_basic();
    sweep(1, 1'b0);
    check_basic("bubble");

    // Randomized sweeps.
    for (int s = 0; s < 40; s++) begin
      ceze    = $urandom;
      cezh    = $urandom;
      src_en  = 1'($urandom_range(0, 1));
      src_idx = 16'($urandom_range(0, N + 1));
      src_val = $urandom;
      for (int i = 0; i < N; i++) begin
        ez_arr[i] = $urandom;
        hy_arr[i] = $urandom;
      end
      rmode = $urandom_range(0, 2);
      sweep(2, 1'($urandom_range(0, 1)));
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
